// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment patterns (bit6=a .. bit0=g),
// special decode codes and the scan decoder frame FSM states.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [3:0] CODE_BLANK = 4'hA;
  localparam logic [3:0] CODE_ERR   = 4'hF;

  typedef enum logic {
    COLLECT,
    HOLD
  } state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the team 7-segment encoding: pattern -> BCD code.
// Blank decodes to CODE_BLANK; anything unrecognised flags err with CODE_ERR.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] code,
  output logic       err
);

  always_comb begin
    code = CODE_ERR;
    err  = 1'b0;
    case (pattern)
      SEG_0:     code = 4'd0;
      SEG_1:     code = 4'd1;
      SEG_2:     code = 4'd2;
      SEG_3:     code = 4'd3;
      SEG_4:     code = 4'd4;
      SEG_5:     code = 4'd5;
      SEG_6:     code = 4'd6;
      SEG_7:     code = 4'd7;
      SEG_8:     code = 4'd8;
      SEG_9:     code = 4'd9;
      SEG_BLANK: code = CODE_BLANK;
      default:   err  = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Snoops a multiplexed 7-segment bus, accepts each digit after a stable dwell,
// and hands complete frames of decoded digits to a consumer via valid/ready.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned STABLE_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     dig_sel,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic [4*DIGITS-1:0]   frame_bcd,
  output logic [DIGITS-1:0]     frame_err,
  output logic                  overrun
);

  localparam int unsigned   CW      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [6:0]          seg_q, seg_prev;
  logic [DIGITS-1:0]   dig_q, dig_prev;
  logic [CW-1:0]       cnt, cnt_next;
  logic                onehot, same, commit;
  logic [DIGITS-1:0]   commit_mask;
  logic [3:0]          dec_code;
  logic                dec_err;

  logic [4*DIGITS-1:0] shadow_bcd;
  logic [DIGITS-1:0]   shadow_err;
  logic [DIGITS-1:0]   captured;
  logic                full;

  state_t state, state_next;
  logic   load, clr, valid_next, ovr_next;

  seg7_pattern_decode u_decode (
    .pattern (seg_q),
    .code    (dec_code),
    .err     (dec_err)
  );

  // Stability tracking on the registered samples; commit fires once per dwell.
  always_comb begin
    onehot = $onehot(dig_q);
    same   = (seg_q == seg_prev) && (dig_q == dig_prev);
    if (!onehot)
      cnt_next = '0;
    else if (same)
      cnt_next = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
    else
      cnt_next = CNT_ONE;
    commit      = (cnt_next == CNT_MAX) && (cnt != CNT_MAX);
    commit_mask = commit ? dig_q : '0;
    full        = &captured;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    clr        = 1'b0;
    valid_next = frame_valid;
    ovr_next   = 1'b0;
    case (state)
      COLLECT: begin
        if (full) begin
          load       = 1'b1;
          clr        = 1'b1;
          valid_next = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (full) begin
          clr = 1'b1;
          if (frame_ready) load     = 1'b1;
          else             ovr_next = 1'b1;
        end else if (frame_ready) begin
          valid_next = 1'b0;
          state_next = COLLECT;
        end
      end
      default: state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= COLLECT;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q       <= '0;
      dig_q       <= '0;
      seg_prev    <= '0;
      dig_prev    <= '0;
      cnt         <= '0;
      shadow_bcd  <= '0;
      shadow_err  <= '0;
      captured    <= '0;
      frame_valid <= 1'b0;
      frame_bcd   <= '0;
      frame_err   <= '0;
      overrun     <= 1'b0;
    end else begin
      seg_q    <= seg_in;
      dig_q    <= dig_sel;
      seg_prev <= seg_q;
      dig_prev <= dig_q;
      cnt      <= cnt_next;
      for (int unsigned i = 0; i < DIGITS; i++) begin
        if (commit_mask[i]) begin
          shadow_bcd[4*i +: 4] <= dec_code;
          shadow_err[i]        <= dec_err;
        end
      end
      // Clear-then-set keeps a same-cycle commit from being lost on frame hand-off.
      captured    <= (clr ? '0 : captured) | commit_mask;
      frame_valid <= valid_next;
      overrun     <= ovr_next;
      if (load) begin
        frame_bcd <= shadow_bcd;
        frame_err <= shadow_err;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder (DIGITS=4, STABLE_CYCLES=3).
module tb_seg7_scan_decoder;

  localparam logic [6:0] P0 = 7'b1111110, P1 = 7'b0110000, P2 = 7'b1101101,
                         P3 = 7'b1111001, P4 = 7'b0110011, P5 = 7'b1011011,
                         P6 = 7'b1011111, P7 = 7'b1110000, P8 = 7'b1111111,
                         P9 = 7'b1111011;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  seg_in = '0;
  logic [3:0]  dig_sel = '0;
  logic        frame_ready = 1'b0;
  logic        frame_valid;
  logic [15:0] frame_bcd;
  logic [3:0]  frame_err;
  logic        overrun;

  int total = 0;
  int bad   = 0;
  int vcnt  = 0;
  int ocnt  = 0;
  int v0, o0;

  seg7_scan_decoder #(.DIGITS(4), .STABLE_CYCLES(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_in      (seg_in),
    .dig_sel     (dig_sel),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_bcd   (frame_bcd),
    .frame_err   (frame_err),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_valid === 1'b1) vcnt++;
    if (overrun === 1'b1) ocnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] d, input logic [6:0] s, input int n);
    @(negedge clk);
    dig_sel = d;
    seg_in  = s;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic idle(input int n);
    drive(4'b0000, 7'b0000000, n);
  endtask

  task automatic scan4(input logic [6:0] a, input logic [6:0] b,
                       input logic [6:0] c, input logic [6:0] d);
    drive(4'b0001, a, 3);
    drive(4'b0010, b, 3);
    drive(4'b0100, c, 3);
    drive(4'b1000, d, 3);
    idle(1);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 20 && frame_valid !== 1'b1; i++) @(negedge clk);
    check({tag, "_valid"}, 32'(frame_valid), 32'd1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 32'(frame_valid), 32'd0);
    check({tag, "_bcd"},   32'(frame_bcd),   32'd0);
    check({tag, "_err"},   32'(frame_err),   32'd0);
    check({tag, "_ovr"},   32'(overrun),     32'd0);
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    check_zero("rst0");
    rst = 1'b0;

    // T1: 1,2,3,4 with ready high -> single-cycle frame 4321
    frame_ready = 1'b1;
    v0 = vcnt;
    scan4(P1, P2, P3, P4);
    wait_valid("t1");
    check("t1_bcd", 32'(frame_bcd), 32'h4321);
    check("t1_err", 32'(frame_err), 32'h0);
    idle(3);
    check("t1_pulse", 32'(vcnt - v0), 32'd1);
    check("t1_drop", 32'(frame_valid), 32'd0);

    // T2: illegal digit 0, blank digit 2
    scan4(7'b1000001, P5, 7'b0000000, P9);
    wait_valid("t2");
    check("t2_bcd", 32'(frame_bcd), 32'h9A5F);
    check("t2_err", 32'(frame_err), 32'h1);
    idle(3);

    // T3: overwrite of digit 0, short dwell on digit 1 is ignored
    v0 = vcnt;
    drive(4'b0001, P2, 3);
    drive(4'b0001, P0, 3);
    drive(4'b0010, P3, 2);
    drive(4'b0010, P7, 3);
    idle(4);
    check("t3_partial", 32'(vcnt - v0), 32'd0);
    drive(4'b0100, P8, 3);
    drive(4'b1000, P6, 3);
    idle(1);
    wait_valid("t3");
    check("t3_bcd", 32'(frame_bcd), 32'h6870);
    check("t3_err", 32'(frame_err), 32'h0);
    idle(3);

    // T4: multi-hot select must not capture anything
    v0 = vcnt;
    drive(4'b0110, P1, 10);
    drive(4'b0001, P4, 3);
    drive(4'b1000, P2, 3);
    idle(4);
    check("t4_multihot", 32'(vcnt - v0), 32'd0);
    drive(4'b0010, P5, 3);
    drive(4'b0100, P6, 3);
    idle(1);
    wait_valid("t4");
    check("t4_bcd", 32'(frame_bcd), 32'h2654);
    idle(3);

    // T5: consumer stalled across two frames -> second frame dropped, one overrun
    frame_ready = 1'b0;
    o0 = ocnt;
    scan4(P5, P6, P7, P8);
    wait_valid("t5");
    check("t5_bcd1", 32'(frame_bcd), 32'h8765);
    scan4(P9, P9, P9, P9);
    idle(4);
    check("t5_ovr", 32'(ocnt - o0), 32'd1);
    check("t5_hold_valid", 32'(frame_valid), 32'd1);
    check("t5_hold_bcd", 32'(frame_bcd), 32'h8765);
    check("t5_hold_err", 32'(frame_err), 32'h0);
    @(negedge clk);
    frame_ready = 1'b1;
    @(negedge clk);
    check("t5_release", 32'(frame_valid), 32'd0);

    // T6: reset mid-frame discards partial capture
    drive(4'b0001, P1, 3);
    drive(4'b0010, P2, 3);
    idle(2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_zero("t6_rst_async");
    repeat (2) @(negedge clk);
    check_zero("t6_rst_hold");
    rst = 1'b0;
    v0 = vcnt;
    drive(4'b0100, P5, 3);
    drive(4'b1000, P6, 3);
    idle(4);
    check("t6_no_partial", 32'(vcnt - v0), 32'd0);
    drive(4'b0001, P3, 3);
    drive(4'b0010, P4, 3);
    idle(1);
    wait_valid("t6");
    check("t6_bcd", 32'(frame_bcd), 32'h6543);
    check("t6_err", 32'(frame_err), 32'h0);
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
